// File: rtl/keccak_slice_streamer.sv
// keccak_slice_streamer: captures a 1600-bit Keccak state, streams its 64 slices over valid/ready.
// Optional per-slice parity is built when SLICE_PAR_EN is defined.
module keccak_slice_streamer #(
  parameter int SLICE_W = 25,
  parameter int NSLICE  = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld,
  input  logic [0:SLICE_W*NSLICE-1]     pin,
  input  logic                          out_ready,
  output logic [0:SLICE_W-1]            slice_out,
  output logic                          slice_valid,
  output logic [$clog2(NSLICE)-1:0]     slice_idx,
  output logic                          slice_par,
  output logic                          busy,
  output logic                          done
);
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t                        r_state, w_next;
  logic [0:SLICE_W*NSLICE-1]     r_shadow;
  logic [$clog2(NSLICE)-1:0]     r_idx;
  logic                          w_hs, w_last, w_load;
  assign w_load = (r_state == IDLE) && ld;
  assign w_hs   = (r_state == STREAM) && out_ready;
  assign w_last = r_idx == ($clog2(NSLICE))'(NSLICE - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = ld ? STREAM : IDLE;
      STREAM:  w_next = (w_hs && w_last) ? DONE : STREAM;
      default: w_next = IDLE;
    endcase
  end
  // The last index is checked before incrementing so idx never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_idx    <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shadow <= pin;
        r_idx    <= '0;
      end else if (w_hs && !w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
  assign slice_valid = r_state == STREAM;
  assign slice_out   = slice_valid ? r_shadow[SLICE_W*r_idx +: SLICE_W] : '0;
  assign slice_idx   = r_idx;
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;
`ifdef SLICE_PAR_EN
  logic r_par;
  // Parity tracks the slice that becomes current at the same edge as the index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par <= 1'b0;
    else if (w_load) r_par <= ^pin[0:SLICE_W-1];
    else if (w_hs && !w_last) r_par <= ^r_shadow[SLICE_W*(r_idx+1) +: SLICE_W];
  end
  assign slice_par = slice_valid & r_par;
`else
  assign slice_par = 1'b0;
`endif
endmodule

// File: tb/tb_keccak_slice_streamer.sv
// tb_keccak_slice_streamer: randomized scenario tasks checked against a slice-queue reference model.
module tb_keccak_slice_streamer;
  logic          clk = 0, rst_n = 0, ld = 0, out_ready = 0;
  logic [0:1599] pin = '0;
  logic [0:24]   slice_out;
  logic          slice_valid, slice_par, busy, done;
  logic [5:0]    slice_idx;
  int            checks = 0, failures = 0;
  logic [24:0]   exp_w[64];
`ifdef SLICE_PAR_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  keccak_slice_streamer dut (
    .clk(clk), .rst_n(rst_n), .ld(ld), .pin(pin), .out_ready(out_ready),
    .slice_out(slice_out), .slice_valid(slice_valid), .slice_idx(slice_idx),
    .slice_par(slice_par), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic run_stream(input int pct, input int hold_at, input int hold_len, input bit poke,
                            output int cyc);
    int n = 0, held = 0;
    bit fin = 0, poked = 0;
    logic [34:0] act, req;
    logic [28:0] act_i;
    for (int k = 0; k < 64; k++) pin[25*k +: 25] = exp_w[k];
    ld = 1;
    @(posedge clk); #1;
    ld = 0;
    for (int k = 0; k < 64; k++) pin[25*k +: 25] = 25'($urandom);
    cyc = 0;
    for (int c = 1; c <= 600 && !fin; c++) begin
      if (n == 64) begin
        act_i = {slice_valid, busy, done, slice_out, slice_par};
        checks++;
        if (act_i !== {3'b011, 26'd0}) begin
          failures++;
          $display("FAIL done_cycle: got %h want %h", act_i, {3'b011, 26'd0});
        end
        cyc = c;
        fin = 1;
      end else begin
        act = {slice_valid, busy, done, slice_idx, slice_out, slice_par};
        req = {3'b110, 6'(n), exp_w[n], PAR & ^exp_w[n]};
        checks++;
        if (act !== req) begin
          failures++;
          $display("FAIL slice n=%0d: got %h want %h", n, act, req);
        end
        if (n == hold_at && held < hold_len) begin
          out_ready = 0;
          held++;
        end else out_ready = $urandom_range(99) < pct;
        if (poke && n == 30 && !poked) begin
          ld = 1;
          pin = '1;
          poked = 1;
        end
        if (out_ready) n++;
        @(posedge clk); #1;
        ld = 0;
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: got %0d slices want 64 plus done", n);
    end
    if (poke) begin
      ld = 1;
      pin = '1;
    end
    @(posedge clk); #1;
    ld = 0;
    act_i = {slice_valid, busy, done, slice_out, slice_par};
    checks++;
    if (act_i !== 29'd0) begin
      failures++;
      $display("FAIL idle_after_done: got %h want 0", act_i);
    end
    if (poke) begin
      @(posedge clk); #1;
      act_i = {slice_valid, busy, done, slice_out, slice_par};
      checks++;
      if (act_i !== 29'd0) begin
        failures++;
        $display("FAIL no_second_stream: got %h want 0", act_i);
      end
    end
  endtask

  task automatic test_reset();
    logic [34:0] act;
    #12;
    act = {slice_valid, busy, done, slice_idx, slice_out, slice_par};
    checks++;
    if (act !== 35'd0) begin
      failures++;
      $display("FAIL reset_state: got %h want 0", act);
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_ordered();
    int cyc;
    for (int k = 0; k < 64; k++) exp_w[k] = 25'(k);
    run_stream(100, -1, 0, 0, cyc);
    checks++;
    if (cyc != 65) begin
      failures++;
      $display("FAIL ordered_done_cycle: got %0d want 65", cyc);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    for (int k = 0; k < 64; k++) exp_w[k] = 25'(k);
    run_stream(100, 10, 5, 0, cyc);
    checks++;
    if (cyc != 70) begin
      failures++;
      $display("FAIL backpressure_done_cycle: got %0d want 70", cyc);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 64; k++) exp_w[k] = 25'($urandom);
      run_stream(30 + 30 * r, -1, 0, 0, cyc);
    end
  endtask

  task automatic test_ignored_load();
    int cyc;
    for (int k = 0; k < 64; k++) exp_w[k] = 25'($urandom);
    run_stream(100, -1, 0, 1, cyc);
    checks++;
    if (cyc != 65) begin
      failures++;
      $display("FAIL ignored_load_done_cycle: got %0d want 65", cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [34:0] act, req;
    for (int k = 0; k < 64; k++) exp_w[k] = 25'($urandom);
    for (int k = 0; k < 64; k++) pin[25*k +: 25] = exp_w[k];
    ld = 1;
    @(posedge clk); #1;
    ld = 0;
    out_ready = 1;
    repeat (20) begin
      @(posedge clk); #1;
    end
    act = {slice_valid, busy, done, slice_idx, slice_out, slice_par};
    req = {3'b110, 6'd20, exp_w[20], PAR & ^exp_w[20]};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL pre_reset_slice20: got %h want %h", act, req);
    end
    #2 rst_n = 0;
    #1;
    act = {slice_valid, busy, done, slice_idx, slice_out, slice_par};
    checks++;
    if (act !== 35'd0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h want 0", act);
    end
    @(posedge clk); #1;
    rst_n = 1;
    for (int k = 0; k < 64; k++) exp_w[k] = 25'($urandom);
    run_stream(100, -1, 0, 0, cyc);
    checks++;
    if (cyc != 65) begin
      failures++;
      $display("FAIL post_reset_done_cycle: got %0d want 65", cyc);
    end
  endtask

  task automatic test_parity();
    int cyc;
    for (int k = 0; k < 64; k++) exp_w[k] = 25'($urandom);
    exp_w[0] = 25'h1FFFFFF;
    exp_w[1] = 25'h0;
    exp_w[2] = 25'h0000003;
    run_stream(80, -1, 0, 0, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 64; k++) exp_w[k] = 25'($urandom);
      run_stream(100, -1, 0, 0, cyc);
      checks++;
      if (cyc != 65) begin
        failures++;
        $display("FAIL back_to_back_done_cycle r=%0d: got %0d want 65", r, cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ordered();
    test_backpressure();
    test_random();
    test_ignored_load();
    test_reset_mid();
    test_parity();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
